// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// response FSM states, word-index bit positions and address-check helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RESP_I = 2'b01,
    S_RESP_D = 2'b10
  } arb_state_e;

  localparam int WORD_LSB = 2;
  localparam int WORD_MSB = 22;
  localparam int IDX_W    = WORD_MSB - WORD_LSB + 1;

  function automatic logic addr_in_range(input logic [IDX_W-1:0] word_idx,
                                         input int unsigned      depth);
    logic [31:0] idx_ext;
    idx_ext = {{(32-IDX_W){1'b0}}, word_idx};
    return (idx_ext < depth);
  endfunction

  function automatic logic addr_aligned(input logic [1:0] byte_off);
    return (byte_off == 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a pending fetch was denied.
// o_sat tells the arbiter that fetch must win the next contended cycle.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; hold once saturated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_sat = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D) ports:
// one grant per cycle, D-priority with bounded fetch starvation, 1-cycle read responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 51,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic        w_sat;
  logic        w_i_gnt;
  logic        w_d_gnt;
  logic [31:0] w_addr;
  logic        w_in_range;
  logic        w_aligned;
  logic        w_d_ok;

  arb_state_e  r_state;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_d_err;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset_n(reset_n),
    .i_inc  (i_req & ~w_i_gnt),
    .i_clr  (w_i_gnt | ~i_req),
    .o_sat  (w_sat)
  );

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset_n) begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
    end else if (i_req && d_req) begin
      w_i_gnt = w_sat;
      w_d_gnt = ~w_sat;
    end else begin
      w_i_gnt = i_req;
      w_d_gnt = d_req;
    end
  end

  // Address mux: fetch address is the idle default.
  always_comb begin
    w_addr = i_addr;
    if (w_d_gnt) begin
      w_addr = d_addr;
    end else begin
      w_addr = i_addr;
    end
  end

  assign w_in_range = addr_in_range(w_addr[WORD_MSB:WORD_LSB], DEPTH);
  assign w_aligned  = addr_aligned(w_addr[1:0]);
  assign w_d_ok     = w_in_range & w_aligned;

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_addr  = w_addr;
  assign mem_wdata = d_wdata;
  assign mem_we    = w_d_gnt & d_we & w_d_ok;

  // Response FSM: records the last read grant and captures its data at the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_i_rdata <= 32'h0000_0000;
      r_d_rdata <= 32'h0000_0000;
      r_d_err   <= 1'b0;
    end else begin
      r_d_err <= w_d_gnt & ~w_d_ok;
      if (w_i_gnt) begin
        r_state   <= S_RESP_I;
        r_i_rdata <= w_in_range ? mem_rdata : 32'h0000_0000;
      end else if (w_d_gnt && !d_we) begin
        r_state   <= S_RESP_D;
        r_d_rdata <= w_d_ok ? mem_rdata : 32'h0000_0000;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign i_rvalid = (r_state == S_RESP_I);
  assign d_rvalid = (r_state == S_RESP_D);
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64-word memory whose
// word k starts as 0x1000_0000 + k.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] tb_mem [0:63];
  logic        mem_init_done = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.DEPTH(51), .STARVE_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 64; k++) tb_mem[k] <= 32'h1000_0000 + 32'(k);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_addr[22:8] == 15'd0) ? tb_mem[mem_addr[7:2]] : 32'hA5A5_A5A5;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 32'h8; d_addr = 32'h10; d_wdata = 32'h0;
    tick; tick;
    total++;
    if ({i_gnt, d_gnt, mem_we} !== 3'b000) begin
      bad++; $display("FAIL reset_gnt: got %b want 000", {i_gnt, d_gnt, mem_we});
    end
    total++;
    if ({i_rvalid, d_rvalid, d_err} !== 3'b000) begin
      bad++; $display("FAIL reset_valid: got %b want 000", {i_rvalid, d_rvalid, d_err});
    end
    total++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
    end
    d_we = 1'b0;
    reset_n = 1'b1;
    #1;
    total++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      bad++; $display("FAIL reset_release_first: got %b want 01", {i_gnt, d_gnt});
    end
    tick;
    i_req = 1'b0; d_req = 1'b0;
    #1;
    total++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h1000_0004}) begin
      bad++; $display("FAIL reset_release_load: got %b/%h want 1/10000004", d_rvalid, d_rdata);
    end
    tick;
  endtask

  task automatic test_i_only;
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b0;
    #1;
    total++;
    if ({i_gnt, d_gnt, mem_we, mem_addr} !== {3'b100, 32'h8}) begin
      bad++; $display("FAIL i_only_gnt: got %b/%h want 100/00000008", {i_gnt, d_gnt, mem_we}, mem_addr);
    end
    tick;
    i_addr = 32'hD;
    #1;
    total++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'h1000_0002}) begin
      bad++; $display("FAIL i_only_rdata: got %b/%h want 1/10000002", i_rvalid, i_rdata);
    end
    tick;
    i_req = 1'b0;
    #1;
    total++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'h1000_0003}) begin
      bad++; $display("FAIL i_only_unaligned: got %b/%h want 1/10000003", i_rvalid, i_rdata);
    end
    tick;
    total++;
    if ({i_rvalid, i_rdata} !== {1'b0, 32'h1000_0003}) begin
      bad++; $display("FAIL i_only_hold: got %b/%h want 0/10000003", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_contention;
    logic exp_i;
    logic prev_i;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h4; d_addr = 32'h0;
    prev_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_i = ((k % 4) == 3);
      #1;
      total++;
      if ({i_gnt, d_gnt, mem_addr} !== {exp_i, ~exp_i, (exp_i ? 32'h4 : 32'h0)}) begin
        bad++; $display("FAIL contention_gnt[%0d]: got %b/%h want %b", k, {i_gnt, d_gnt}, mem_addr, {exp_i, ~exp_i});
      end
      if (k > 0) begin
        total++;
        if ({i_rvalid, d_rvalid} !== {prev_i, ~prev_i}) begin
          bad++; $display("FAIL contention_rvalid[%0d]: got %b want %b", k, {i_rvalid, d_rvalid}, {prev_i, ~prev_i});
        end
      end
      prev_i = exp_i;
      tick;
    end
    tick; tick;
    i_req = 1'b0;
    tick;
    i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k == 3);
      #1;
      total++;
      if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        bad++; $display("FAIL contention_clear[%0d]: got %b want %b", k, {i_gnt, d_gnt}, {exp_i, ~exp_i});
      end
      tick;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick;
  endtask

  task automatic test_store_load;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({d_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h14, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL store_drive: got %b/%h/%h want 11/00000014/deadbeef", {d_gnt, mem_we}, mem_addr, mem_wdata);
    end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    total++;
    if ({d_rvalid, d_err, mem_we} !== 3'b000) begin
      bad++; $display("FAIL store_no_resp: got %b want 000", {d_rvalid, d_err, mem_we});
    end
    d_req = 1'b1;
    #1;
    total++;
    if ({d_gnt, mem_we} !== 2'b10) begin
      bad++; $display("FAIL load_gnt: got %b want 10", {d_gnt, mem_we});
    end
    tick;
    d_req = 1'b0;
    #1;
    total++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL load_back: got %b/%h want 10/deadbeef", {d_rvalid, d_err}, d_rdata);
    end
    tick;
  endtask

  task automatic test_errors;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hCC;
    tick;
    d_req = 1'b0;
    #1;
    total++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL load_oor: got %b/%h want 11/00000000", {d_rvalid, d_err}, d_rdata);
    end
    d_req = 1'b1; d_addr = 32'h8;
    tick;
    d_req = 1'b0;
    #1;
    total++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h1000_0002}) begin
      bad++; $display("FAIL load_ok: got %b/%h want 10/10000002", {d_rvalid, d_err}, d_rdata);
    end
    d_req = 1'b1; d_addr = 32'h3;
    #1;
    total++;
    if ({d_gnt, mem_we} !== 2'b10) begin
      bad++; $display("FAIL load_misaligned_gnt: got %b want 10", {d_gnt, mem_we});
    end
    tick;
    d_req = 1'b0;
    #1;
    total++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL load_misaligned: got %b/%h want 11/00000000", {d_rvalid, d_err}, d_rdata);
    end
    tick;
    total++;
    if ({d_rvalid, d_err} !== 2'b00) begin
      bad++; $display("FAIL err_pulse: got %b want 00", {d_rvalid, d_err});
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hCC; d_wdata = 32'h1234_5678;
    #1;
    total++;
    if ({d_gnt, mem_we} !== 2'b10) begin
      bad++; $display("FAIL store_oor_we: got %b want 10", {d_gnt, mem_we});
    end
    tick;
    d_addr = 32'h16;
    #1;
    total++;
    if ({d_rvalid, d_err, mem_we} !== 3'b010) begin
      bad++; $display("FAIL store_oor_err: got %b want 010", {d_rvalid, d_err, mem_we});
    end
    tick;
    d_addr = 32'hC8; d_wdata = 32'hCAFE_0001;
    #1;
    total++;
    if ({d_err, mem_we} !== 2'b11) begin
      bad++; $display("FAIL store_last_word: got %b want 11", {d_err, mem_we});
    end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    total++;
    if (d_err !== 1'b0) begin
      bad++; $display("FAIL store_last_err: got %b want 0", d_err);
    end
    i_req = 1'b1; i_addr = 32'hC8;
    tick;
    i_addr = 32'hCC;
    #1;
    total++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'hCAFE_0001}) begin
      bad++; $display("FAIL i_last_word: got %b/%h want 1/cafe0001", i_rvalid, i_rdata);
    end
    tick;
    i_req = 1'b0;
    #1;
    total++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL i_oor: got %b/%h want 1/00000000", i_rvalid, i_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    logic exp_i;
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
    tick;
    d_req = 1'b1;
    tick; tick; tick;
    total++;
    if (i_gnt !== 1'b1) begin
      bad++; $display("FAIL mid_pre_gnt: got %b want 1", i_gnt);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({i_gnt, d_gnt, mem_we} !== 3'b000) begin
      bad++; $display("FAIL mid_gnt_drop: got %b want 000", {i_gnt, d_gnt, mem_we});
    end
    tick;
    total++;
    if ({i_rvalid, d_rvalid, i_rdata} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL mid_no_resp: got %b/%h want 00/00000000", {i_rvalid, d_rvalid}, i_rdata);
    end
    tick;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k == 3);
      #1;
      total++;
      if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        bad++; $display("FAIL mid_starve_cleared[%0d]: got %b want %b", k, {i_gnt, d_gnt}, {exp_i, ~exp_i});
      end
      if (k == 0) begin
        total++;
        if (i_rvalid !== 1'b0) begin
          bad++; $display("FAIL mid_rvalid_after: got %b want 0", i_rvalid);
        end
      end
      tick;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_i_only;
    test_contention;
    test_store_load;
    test_errors;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
